// File: rtl/vga_pkg.sv
// Shared timing constants and decoder state type for the VGA timing chain.
package vga_pkg;

   localparam int H_TOTAL_NOM      = 1056;
   localparam int V_TOTAL_NOM      = 628;
   localparam int H_SYNC_START_NOM = 840;
   localparam int V_SYNC_START_NOM = 601;

   localparam logic [11:0] CNT_SAT = 12'hFFF;

   typedef enum logic [1:0] {
      SEARCH,
      MEASURE,
      LOCKED
   } dec_state_t;

endpackage

// File: rtl/vga_sync_edge_det.sv
// Normalises a sync input to active-high and flags its active (leading) edge.
module vga_sync_edge_det #(
   parameter bit ACTIVE_HIGH = 1'b1
) (
   input  logic pclk,
   input  logic rst,
   input  logic sync,
   output logic active_edge
);

   logic sync_act;
   logic sync_q;

   assign sync_act = ACTIVE_HIGH ? sync : ~sync;

   // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge pclk) begin
      if (rst) sync_q <= 1'b0;
      else     sync_q <= sync_act;
   end

   assign active_edge = sync_act & ~sync_q;

endmodule

// File: rtl/vga_timing_decoder.sv
// Rebuilds hcount/vcount from hsync/vsync, measures line/frame length and tracks lock.
module vga_timing_decoder
   import vga_pkg::*;
#(
   parameter int H_TOTAL          = H_TOTAL_NOM,
   parameter int V_TOTAL          = V_TOTAL_NOM,
   parameter int H_SYNC_START     = H_SYNC_START_NOM,
   parameter int V_SYNC_START     = V_SYNC_START_NOM,
   parameter bit SYNC_ACTIVE_HIGH = 1'b1
) (
   input  logic        pclk,
   input  logic        rst,
   input  logic        hsync,
   input  logic        vsync,
   output logic [10:0] hcount,
   output logic [10:0] vcount,
   output logic        locked,
   output logic        err,
   output logic [11:0] line_len,
   output logic [11:0] frame_len
);

   localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
   localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
   localparam logic [10:0] H_LOAD   = 11'(H_SYNC_START);
   localparam logic [10:0] V_LOAD   = 11'(V_SYNC_START);
   localparam logic [12:0] LINE_NOM = 13'(H_TOTAL);
   localparam logic [11:0] FRAME_NOM = 12'(V_TOTAL);
   localparam logic [11:0] TIMEOUT  = 12'(2 * H_TOTAL);

   logic        h_edge, v_edge, h_wrap;
   logic [11:0] line_cnt, frame_cnt;
   logic [12:0] line_inc;
   logic        line_sat, line_bad, frame_bad, timeout;

   dec_state_t  state, state_next;
   logic        first_line, first_line_next;
   logic        ok, ok_next;
   logic        err_next;

   vga_sync_edge_det #(.ACTIVE_HIGH(SYNC_ACTIVE_HIGH)) u_h_edge (
      .pclk(pclk), .rst(rst), .sync(hsync), .active_edge(h_edge)
   );

   vga_sync_edge_det #(.ACTIVE_HIGH(SYNC_ACTIVE_HIGH)) u_v_edge (
      .pclk(pclk), .rst(rst), .sync(vsync), .active_edge(v_edge)
   );

   assign h_wrap    = (hcount == H_LAST) && !h_edge;
   assign line_inc  = {1'b0, line_cnt} + 13'd1;
   assign line_sat  = (line_cnt == CNT_SAT);
   assign line_bad  = (line_inc != LINE_NOM);
   assign frame_bad = (frame_cnt != FRAME_NOM);
   assign timeout   = (line_cnt == TIMEOUT);

   always_ff @(posedge pclk) begin
      if (rst) begin
         hcount    <= '0;
         vcount    <= '0;
         line_cnt  <= '0;
         frame_cnt <= '0;
         line_len  <= '0;
         frame_len <= '0;
      end else begin
         if (h_edge)      hcount <= H_LOAD;
         else if (h_wrap) hcount <= '0;
         else             hcount <= hcount + 11'd1;

         // A v-edge load overrides the line-wrap increment in the same cycle.
         if (v_edge)      vcount <= V_LOAD;
         else if (h_wrap) vcount <= (vcount == V_LAST) ? '0 : vcount + 11'd1;

         if (h_edge) begin
            line_len <= line_sat ? CNT_SAT : line_inc[11:0];
            line_cnt <= '0;
         end else if (!line_sat) begin
            line_cnt <= line_cnt + 12'd1;
         end

         // frame_cnt latches its pre-increment value; a coincident h-edge is dropped.
         if (v_edge) begin
            frame_len <= frame_cnt;
            frame_cnt <= '0;
         end else if (h_edge && frame_cnt != CNT_SAT) begin
            frame_cnt <= frame_cnt + 12'd1;
         end
      end
   end

   always_ff @(posedge pclk) begin
      if (rst) begin
         state      <= SEARCH;
         first_line <= 1'b0;
         ok         <= 1'b0;
         err        <= 1'b0;
      end else begin
         state      <= state_next;
         first_line <= first_line_next;
         ok         <= ok_next;
         err        <= err_next;
      end
   end

   // NOTE: every always_comb output is defaulted first so no path can infer a latch.
   always_comb begin
      state_next      = state;
      first_line_next = first_line;
      ok_next         = ok;
      err_next        = 1'b0;
      unique case (state)
         SEARCH: begin
            if (v_edge) begin
               state_next      = MEASURE;
               first_line_next = 1'b0;
               ok_next         = 1'b1;
            end
         end
         MEASURE: begin
            if (h_edge) begin
               if (!first_line)   first_line_next = 1'b1;
               else if (line_bad) ok_next = 1'b0;
            end
            if (timeout) begin
               state_next = SEARCH;
               err_next   = 1'b1;
            end else if (v_edge) begin
               if (ok_next && !frame_bad) begin
                  state_next = LOCKED;
               end else begin
                  state_next = SEARCH;
                  err_next   = 1'b1;
               end
            end
         end
         LOCKED: begin
            if ((h_edge && line_bad) || (v_edge && frame_bad) || timeout) begin
               state_next = SEARCH;
               err_next   = 1'b1;
            end
         end
         default: state_next = SEARCH;
      endcase
   end

   assign locked = (state == LOCKED);

endmodule

// File: tb/tb_vga_timing_decoder.sv
// Directed bench: a behavioural sync generator drives two decoders (active-high and active-low syncs).
module tb_vga_timing_decoder;

   localparam int H  = 40;
   localparam int V  = 12;
   localparam int HS = 30;
   localparam int VS = 9;
   localparam int HW = 4;
   localparam int VW = 2;

   logic        pclk = 1'b0;
   logic        rst;
   logic        hsync, vsync, hsync_n, vsync_n;
   logic [10:0] hcount_p, vcount_p, hcount_n, vcount_n;
   logic        locked_p, err_p, locked_n, err_n;
   logic [11:0] line_len_p, frame_len_p, line_len_n, frame_len_n;

   int n_checks = 0;
   int n_fail   = 0;

   int gh, gv, cur_htot, cur_vtot;
   bit hs_kill, track;
   int mism_p, mism_n, err_cnt_p, err_cnt_n;

   always #5 pclk = ~pclk;

   vga_timing_decoder #(
      .H_TOTAL(H), .V_TOTAL(V), .H_SYNC_START(HS), .V_SYNC_START(VS), .SYNC_ACTIVE_HIGH(1'b1)
   ) dut_p (
      .pclk(pclk), .rst(rst), .hsync(hsync), .vsync(vsync),
      .hcount(hcount_p), .vcount(vcount_p), .locked(locked_p), .err(err_p),
      .line_len(line_len_p), .frame_len(frame_len_p)
   );

   vga_timing_decoder #(
      .H_TOTAL(H), .V_TOTAL(V), .H_SYNC_START(HS), .V_SYNC_START(VS), .SYNC_ACTIVE_HIGH(1'b0)
   ) dut_n (
      .pclk(pclk), .rst(rst), .hsync(hsync_n), .vsync(vsync_n),
      .hcount(hcount_n), .vcount(vcount_n), .locked(locked_n), .err(err_n),
      .line_len(line_len_n), .frame_len(frame_len_n)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic drive();
      logic hs_a, vs_a;
      hs_a    = (gh >= HS) && (gh < HS + HW) && !hs_kill;
      vs_a    = (gv >= VS) && (gv < VS + VW);
      hsync   = hs_a;
      vsync   = vs_a;
      hsync_n = ~hs_a;
      vsync_n = ~vs_a;
   endtask

   task automatic advance();
      if (gh >= cur_htot - 1) begin
         gh       = 0;
         cur_htot = H;
         if (gv >= cur_vtot - 1) begin
            gv       = 0;
            cur_vtot = V;
         end else begin
            gv++;
         end
      end else begin
         gh++;
      end
   endtask

   // Outputs sampled 1 time unit after the edge reflect the inputs of position (gh, gv).
   task automatic tick();
      @(posedge pclk);
      #1;
      if (track) begin
         if (hcount_p !== 11'(gh) || vcount_p !== 11'(gv)) mism_p++;
         if (hcount_n !== 11'(gh) || vcount_n !== 11'(gv)) mism_n++;
      end
      if (err_p === 1'b1) err_cnt_p++;
      if (err_n === 1'b1) err_cnt_n++;
      advance();
      drive();
   endtask

   task automatic wait_pos(input int h, input int v);
      int n;
      n = 0;
      while (!(gh == h && gv == v) && n < 3000) begin
         tick();
         n++;
      end
      check("wait_reached", 32'(gh == h && gv == v), 1);
   endtask

   task automatic wait_vedge();
      wait_pos(0, VS);
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_hcount"}, hcount_p, 0);
      check({tag, "_vcount"}, vcount_p, 0);
      check({tag, "_locked"}, locked_p, 0);
      check({tag, "_err"}, err_p, 0);
      check({tag, "_line_len"}, line_len_p, 0);
      check({tag, "_frame_len"}, frame_len_p, 0);
      check({tag, "_locked_n"}, locked_n, 0);
   endtask

   initial begin
      int e0;
      rst = 1'b1; gh = 0; gv = 0; cur_htot = H; cur_vtot = V;
      hs_kill = 1'b0; track = 1'b0;
      mism_p = 0; mism_n = 0; err_cnt_p = 0; err_cnt_n = 0;
      drive();
      repeat (3) begin @(posedge pclk); #1; end
      check_zero("reset");
      rst = 1'b0;

      // Nominal timing from reset: lock one cycle after the second v-edge.
      wait_vedge();
      tick();
      check("s1_measure_locked", locked_p, 0);
      wait_vedge();
      check("s1_pre_lock", locked_p, 0);
      tick();
      check("s1_locked_p", locked_p, 1);
      check("s1_locked_n", locked_n, 1);
      check("s1_line_len_p", line_len_p, H);
      check("s1_frame_len_p", frame_len_p, V);
      check("s1_line_len_n", line_len_n, H);
      check("s1_frame_len_n", frame_len_n, V);
      check("s1_err_cnt", err_cnt_p, 0);
      track = 1'b1;
      wait_vedge();
      tick();
      track = 1'b0;
      check("s1_track_p", mism_p, 0);
      check("s1_track_n", mism_n, 0);
      check("s1_still_locked", locked_p, 1);
      check("s1_no_err", err_cnt_p + err_cnt_n, 0);

      // One line shortened by a cycle while locked.
      e0 = err_cnt_p;
      wait_pos(0, 3);
      cur_htot = H - 1;
      wait_pos(HS, 4);
      check("s2_pre_err", err_p, 0);
      tick();
      check("s2_err", err_p, 1);
      check("s2_unlocked", locked_p, 0);
      check("s2_line_len", line_len_p, H - 1);
      check("s2_unlocked_n", locked_n, 0);
      tick();
      check("s2_err_one_cycle", err_p, 0);
      wait_vedge();
      tick();
      check("s2_measure", locked_p, 0);
      wait_vedge();
      tick();
      check("s2_relock", locked_p, 1);
      check("s2_err_pulses", err_cnt_p - e0, 1);

      // hsync held inactive while locked: timeout at line_cnt == 2*H.
      wait_pos(HS, 2);
      tick();
      hs_kill = 1'b1;
      repeat (2 * H) tick();
      check("s3_pre_timeout_err", err_p, 0);
      check("s3_pre_timeout_locked", locked_p, 1);
      tick();
      check("s3_timeout_err", err_p, 1);
      check("s3_timeout_locked", locked_p, 0);
      check("s3_line_len_kept", line_len_p, H);
      wait_pos(0, 5);
      hs_kill = 1'b0;

      // Short frame during MEASURE, then a correct frame pair relocks.
      wait_vedge();
      tick();
      check("s4_measure", locked_p, 0);
      cur_vtot = V - 1;
      wait_vedge();
      check("s4_pre_err", err_p, 0);
      tick();
      check("s4_err", err_p, 1);
      check("s4_no_lock", locked_p, 0);
      check("s4_frame_len", frame_len_p, V - 1);
      wait_vedge();
      tick();
      check("s4_measure2", locked_p, 0);
      wait_vedge();
      tick();
      check("s4_relock", locked_p, 1);
      check("s4_relock_n", locked_n, 1);
      check("s4_frame_len_ok", frame_len_p, V);

      // Synchronous reset mid-frame while locked.
      wait_pos(5, 4);
      rst = 1'b1;
      tick();
      check_zero("s6_reset");
      rst = 1'b0;
      wait_vedge();
      tick();
      check("s6_measure", locked_p, 0);
      wait_vedge();
      check("s6_pre_lock", locked_p, 0);
      tick();
      check("s6_relock", locked_p, 1);
      check("s6_relock_n", locked_n, 1);
      check("s6_frame_len", frame_len_p, V);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/vga_timing_decoder.md
Name: vga_timing_decoder

Overview:
- Receive side of the VGA timing chain: consumes hsync/vsync produced by the horizontal/vertical counters and sync generator, and reconstructs hcount/vcount locally.
- Measures line and frame lengths, checks them against nominal totals, and reports lock and errors.
- Used by overlay, capture and self-check logic that sees only sync signals, not the generator's counters.

Parameters:
- H_TOTAL, 1056, pclk cycles per line
- V_TOTAL, 628, lines per frame
- H_SYNC_START, 840, hcount value at which hsync becomes active
- V_SYNC_START, 601, vcount value at which vsync becomes active
- SYNC_ACTIVE_HIGH, 1, sync polarity (1 = active-high, 0 = active-low)

Ports:
- pclk  in  1  pixel clock
- rst  in  1  reset, synchronous, active-high
- hsync  in  1  horizontal sync, pclk domain
- vsync  in  1  vertical sync, pclk domain
- hcount  out  11  reconstructed horizontal position
- vcount  out  11  reconstructed vertical position
- locked  out  1  timing verified, counters valid
- err  out  1  one-cycle pulse on lock failure or loss
- line_len  out  12  last measured line length in cycles (saturating)
- frame_len  out  12  last measured frame length in lines (saturating)

Behaviour:
- Reset: hcount=0, vcount=0, locked=0, err=0, line_len=0, frame_len=0, state=SEARCH, internal counters 0, edge registers loaded with the inactive level.
- Edge detect:
  - Sync inputs are normalised to active-high, then registered once (h_q, v_q).
  - Active edge at cycle t: input active and register inactive.
- hcount:
  - On an h-edge at t, loads H_SYNC_START, visible at t+1.
  - Otherwise increments; H_TOTAL-1 wraps to 0.
- vcount:
  - Increments when hcount wraps; V_TOTAL-1 wraps to 0.
  - On a v-edge, loads V_SYNC_START.
  - A v-edge in the same cycle as an hcount wrap: the load wins.
- line_cnt:
  - On an h-edge: line_len <= line_cnt+1, and line_cnt <= 0.
  - Otherwise line_cnt increments, saturating at 4095.
- frame_cnt:
  - Increments on each h-edge.
  - On a v-edge: frame_len <= frame_cnt, and frame_cnt <= 0.
  - Saturates at 4095.
- FSM states SEARCH, MEASURE, LOCKED:
  - SEARCH: locked=0. First v-edge -> MEASURE. Clear first_line flag, ok flag=1.
  - MEASURE: locked=0.
    - First h-edge: sets first_line only; the partial line is not checked.
    - Each later h-edge with line_cnt+1 != H_TOTAL: ok=0.
    - Next v-edge: if ok and frame_cnt == V_TOTAL -> LOCKED. Otherwise -> SEARCH and pulse err.
  - LOCKED: locked=1. Any of the following pulses err for one cycle and moves to SEARCH:
    - h-edge with line_cnt+1 != H_TOTAL
    - v-edge with frame_cnt != V_TOTAL
    - line_cnt reaching 2*H_TOTAL (missing hsync)
    - In all three cases, locked drops the next cycle.
- Timeout (line_cnt == 2*H_TOTAL) also applies in MEASURE: -> SEARCH with err.
- hcount/vcount keep running in every state. Consumers qualify them with locked.
- Latency:
  - hcount lags the generator's hcount by one pclk for a generator with registered sync outputs.
  - locked asserts one cycle after the v-edge that completes MEASURE.
- Reset mid-frame: everything returns to reset values. A full SEARCH->MEASURE->LOCKED sequence is needed again, at least one full frame plus partial.
- Simultaneous h-edge and v-edge: both are processed in the same cycle.
  - frame_cnt uses its pre-increment value for the check and latch.
  - The h-edge's increment is discarded (counter cleared).

Decomposition:
- vga_pkg holds:
  - nominal timing constants (H_TOTAL, V_TOTAL, sync start values), which serve as parameter defaults
  - the decoder state enum typedef (SEARCH, MEASURE, LOCKED)
- Sub-module vga_sync_edge_det: polarity normalise, register, active-edge pulse. Instantiated twice (hsync, vsync).

Test Plan:
- Drive the reference generator (vga_h_counter plus vertical counter/sync) at nominal timing from reset -> locked=1 one cycle after the second v-edge. hcount equals generator hcount delayed one cycle. line_len=1056, frame_len=628.
- Locked, then one line shortened to 1055 cycles -> err pulses once at that h-edge, locked=0 next cycle, relock after the following full measured frame.
- Locked, then hsync held inactive -> err when line_cnt reaches 2112, state SEARCH, line_len unchanged.
- Frame with 627 lines during MEASURE -> err at the closing v-edge, no lock. The next correct frame pair gives locked=1.
- SYNC_ACTIVE_HIGH=0 with inverted syncs -> identical lock timing and counts to the first scenario.
- Assert rst for 1 cycle mid-frame while locked -> all outputs 0 the next cycle, relock after the full sequence.
